// File: rtl/cgra_pkg.sv
// rtl/cgra_pkg.sv - shared CGRA constants and input-node reader state type
package cgra_pkg;

    localparam int IMN_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } imn_fsm_t;

endpackage

// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI request/response bundle types
package obi_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/imn_resp_fifo.sv
// rtl/imn_resp_fifo.sv - power-of-two response buffer between OBI read data and the word stream
module imn_resp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/imn_stream_reader.sv
// rtl/imn_stream_reader.sv - OBI strided reader feeding a CGRA input node; IMN_STALL_CTR_EN adds a grant-stall counter
module imn_stream_reader
    import cgra_pkg::*;
    import obi_pkg::*;
#(
    parameter int FIFO_DEPTH = IMN_FIFO_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    input  logic [15:0] size_i,
    input  logic [15:0] stride_i,
    output obi_req_t    obi_req_o,
    input  obi_resp_t   obi_resp_i,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        done_o
`ifdef IMN_STALL_CTR_EN
    ,
    output logic [31:0] stall_cycles_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    imn_fsm_t      state_q, state_d;
    logic [31:0]   addr_q;
    logic [15:0]   stride_q;
    logic [13:0]   remaining_q;
    logic [CW-1:0] outstanding_q;
    logic          done_q;

    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW:0]   inflight;
    logic [13:0]   words;
    logic          req;
    logic          gnt_hs;
    logic          push;
    logic          pop;
    logic          xfer_done;
    logic          size_lsb_unused;

    assign words           = size_i[15:2];
    assign size_lsb_unused = ^size_i[1:0];
    assign inflight        = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign req             = (state_q == S_FETCH) && (inflight < (CW+1)'(FIFO_DEPTH));
    assign gnt_hs          = req && obi_resp_i.gnt;
    // Data with nothing outstanding belongs to a transfer killed by reset.
    assign push            = obi_resp_i.rvalid && (outstanding_q != '0);
    assign valid_o         = !fifo_empty;
    assign pop             = valid_o && ready_i;
    assign xfer_done       = (state_q == S_DRAIN) && (outstanding_q == '0) && fifo_empty;
    assign done_o          = done_q || xfer_done;

    always_comb begin
        obi_req_o      = '0;
        obi_req_o.req  = req;
        obi_req_o.addr = addr_q;
        obi_req_o.be   = 4'hF;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i && (words != '0)) state_d = S_FETCH;
            S_FETCH: if (gnt_hs && (remaining_q == 14'd1)) state_d = S_DRAIN;
            S_DRAIN: if (xfer_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            stride_q      <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == S_IDLE) && start_i && (words == '0);
            if ((state_q == S_IDLE) && start_i) begin
                addr_q      <= addr_i;
                stride_q    <= stride_i;
                remaining_q <= words;
            end else if (gnt_hs) begin
                addr_q      <= addr_q + {16'h0000, stride_q};
                remaining_q <= remaining_q - 14'd1;
            end
            case ({gnt_hs, push})
                2'b10:   outstanding_q <= outstanding_q + CW'(1);
                2'b01:   outstanding_q <= outstanding_q - CW'(1);
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

`ifdef IMN_STALL_CTR_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cycles_o <= '0;
        end else if (start_i) begin
            stall_cycles_o <= '0;
        end else if (req && !obi_resp_i.gnt && (stall_cycles_o != '1)) begin
            stall_cycles_o <= stall_cycles_o + 32'd1;
        end
    end
`endif

    imn_resp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (obi_resp_i.rdata),
        .pop_i   (pop),
        .data_o  (data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The in-flight cap guarantees every response has a free slot.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));

endmodule

// File: tb/tb_imn_stream_reader.sv
// tb/tb_imn_stream_reader.sv - self-checking bench for imn_stream_reader
module tb_imn_stream_reader;
    import obi_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] addr = '0;
    logic [15:0] size = '0;
    logic [15:0] stride = '0;
    obi_req_t    req;
    obi_resp_t   resp;
    logic [31:0] data;
    logic        valid;
    logic        ready = 1'b1;
    logic        done;
    logic        gnt_en = 1'b1;
    logic        slv_rvalid = 1'b0;
    logic [31:0] slv_rdata = '0;
`ifdef IMN_STALL_CTR_EN
    logic [31:0] stall;
`endif

    int n_vec = 0;
    int n_err = 0;

    int          m_words, m_gi, m_pi;
    logic [31:0] m_base;
    logic [15:0] m_stride;
    bit          m_busy = 0, m_done_due = 0;
    logic [31:0] obs_addr [16];
    logic [31:0] obs_data [16];
    bit          hold_req = 0, hold_data = 0;
    logic [31:0] hold_addr, hold_val;

    always #5 clk = ~clk;

    assign resp = '{gnt: gnt_en, rvalid: slv_rvalid, rdata: slv_rdata};

    imn_stream_reader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .addr_i     (addr),
        .size_i     (size),
        .stride_i   (stride),
        .obi_req_o  (req),
        .obi_resp_i (resp),
        .data_o     (data),
        .valid_o    (valid),
        .ready_i    (ready),
        .done_o     (done)
`ifdef IMN_STALL_CTR_EN
        ,
        .stall_cycles_o (stall)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input int i);
        return m_base + 32'(i) * {16'h0000, m_stride};
    endfunction

    // Memory slave: granted reads return addr ^ 0xDEAD0000 one cycle later.
    initial begin
        logic        hs;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            hs = req.req && gnt_en;
            a  = req.addr;
            @(posedge clk);
            #1;
            slv_rvalid = hs;
            slv_rdata  = a ^ 32'hDEAD_0000;
        end
    end

    // Transfer model and per-cycle compare.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_busy = 0; m_done_due = 0; hold_req = 0; hold_data = 0;
                m_gi = 0; m_pi = 0; m_words = 0;
                continue;
            end
            chk("done", done, m_done_due);
            if (m_done_due) begin
                m_done_due = 0;
                m_busy = 0;
            end
            if (hold_req) begin
                chk("req_hold", req.req, 1);
                chk("addr_hold", req.addr, hold_addr);
            end
            if (hold_data) begin
                chk("valid_hold", valid, 1);
                chk("data_hold", data, hold_val);
            end
            if (req.req) begin
                if (!(m_busy && m_gi < m_words)) begin
                    chk("spurious_req", req.req, 0);
                end else if (gnt_en) begin
                    chk("addr", req.addr, exp_addr(m_gi));
                    chk("we_be", {27'h0, req.we, req.be}, 32'h0000_000F);
                    chk("inflight_cap", (m_gi - m_pi) < DEPTH, 1);
                    obs_addr[m_gi] = req.addr;
                    m_gi++;
                end
            end
            if (valid) begin
                if (m_pi >= m_gi) begin
                    chk("spurious_valid", valid, 0);
                end else if (ready) begin
                    chk("data", data, exp_addr(m_pi) ^ 32'hDEAD_0000);
                    obs_data[m_pi] = data;
                    m_pi++;
                    if (m_pi == m_words) m_done_due = 1;
                end
            end
            hold_req  = req.req && !gnt_en;
            hold_addr = req.addr;
            hold_data = valid && !ready;
            hold_val  = data;
            if (start && !m_busy && !m_done_due) begin
                m_words  = int'(size[15:2]);
                m_base   = addr;
                m_stride = stride;
                m_gi = 0;
                m_pi = 0;
                if (m_words == 0) m_done_due = 1;
                else m_busy = 1;
            end
        end
    end

    task automatic launch(input logic [31:0] a, input logic [15:0] s, input logic [15:0] st);
        @(posedge clk); #1;
        addr = a; size = s; stride = st; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_busy || m_done_due) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= budget) chk("timeout", 0, 1);
    endtask

    task automatic run_basic();
        launch(32'h1000, 16'd16, 16'd4);
        wait_idle(100);
        chk("a_addr0", obs_addr[0], 32'h0000_1000);
        chk("a_addr1", obs_addr[1], 32'h0000_1004);
        chk("a_addr2", obs_addr[2], 32'h0000_1008);
        chk("a_addr3", obs_addr[3], 32'h0000_100C);
        chk("a_data0", obs_data[0], 32'hDEAD_1000);
        chk("a_data3", obs_data[3], 32'hDEAD_100C);
        chk("a_words", m_pi, 4);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", req.req, 0);
        chk("rst_valid", valid, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;

        run_basic();

        launch(32'h0, 16'd8, 16'hFFFC);
        wait_idle(100);
        chk("b_addr0", obs_addr[0], 32'h0000_0000);
        chk("b_addr1", obs_addr[1], 32'h0000_FFFC);
        chk("b_data1", obs_data[1], 32'hDEAD_FFFC);

        ready = 1'b0;
        launch(32'h2000, 16'd32, 16'd4);
        repeat (19) @(posedge clk);
        #1;
        chk("c_grants", m_gi, 4);
        chk("c_req_low", req.req, 0);
        chk("c_valid", valid, 1);
        chk("c_head", data, 32'hDEAD_2000);
        ready = 1'b1;
        wait_idle(200);
        chk("c_total", m_pi, 8);

        launch(32'h3000, 16'd3, 16'd4);
        chk("d_done", done, 1);
        chk("d_req", req.req, 0);
        wait_idle(10);
        chk("d_grants", m_gi, 0);

        launch(32'h1000, 16'd16, 16'd4);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("e_grants", m_gi, 2);
        rst_n = 1'b0;
        #1;
        chk("e_req", req.req, 0);
        chk("e_valid", valid, 0);
        chk("e_done", done, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("e_valid_after", valid, 0);
        chk("e_req_after", req.req, 0);
        run_basic();

`ifdef IMN_STALL_CTR_EN
        gnt_en = 1'b0;
        launch(32'h4000, 16'd8, 16'd4);
        repeat (5) @(posedge clk);
        #1;
        gnt_en = 1'b1;
        wait_idle(100);
        chk("stall_cycles", stall, 32'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/imn_stream_reader.md
IMN_STREAM_READER -- requirements
Module: imn_stream_reader

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, the number of response-buffer entries and the cap on in-flight reads; power of two, at least 2.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start_i, input, 1 bit: single-cycle launch pulse from the control registers.
REQ-005 SHALL have ports addr_i (input, 32 bits), size_i (input, 16 bits) and stride_i (input, 16 bits): base byte address, transfer length in bytes, and byte increment per word.
REQ-006 SHALL have OBI master port obi_req_o, output, obi_req_t: req, addr, we=0, be=4'hF, wdata=0.
REQ-007 SHALL have OBI response port obi_resp_i, input, obi_resp_t: gnt, rvalid, rdata.
REQ-008 SHALL have ports data_o (output, 32 bits), valid_o (output, 1 bit) and ready_i (input, 1 bit): word stream into the CGRA input node.
REQ-009 SHALL have port done_o, output, 1 bit: one-cycle pulse when the transfer completes.

Function
REQ-010 SHALL sample addr_i, size_i and stride_i on the start_i cycle; word count = size_i[15:2], and size_i[1:0] is ignored.
REQ-011 SHALL implement FSM S_IDLE -> S_FETCH on start_i when word count is nonzero, S_FETCH -> S_DRAIN after the last grant, and S_DRAIN -> S_IDLE when the transfer completes.
REQ-012 SHALL, on start_i in S_IDLE with word count 0, pulse done_o on the next cycle, issue no request, and remain in S_IDLE.
REQ-013 SHALL ignore start_i outside S_IDLE.
REQ-014 SHALL assert obi_req_o.req no earlier than the cycle after start_i, and only while in S_FETCH and (outstanding + fifo_count) < FIFO_DEPTH.
REQ-015 SHALL hold req and addr stable until gnt is seen; on gnt, advance addr by stride_i modulo 2^32 and decrement the remaining count.
REQ-016 SHALL increment the outstanding count on gnt, decrement it on rvalid, and leave it unchanged when both occur in the same cycle.
REQ-017 SHALL push rdata into the FIFO on rvalid; overflow is impossible by REQ-014, and an assertion SHALL check it.
REQ-018 SHALL drive valid_o = FIFO not empty and data_o = FIFO head, popping on valid_o && ready_i; simultaneous push and pop keeps the count.
REQ-019 SHALL make valid_o independent of ready_i, and SHALL keep data_o stable while valid_o && !ready_i.
REQ-020 SHALL complete the transfer when all words are granted, outstanding = 0 and the FIFO is empty: done_o high for exactly that cycle, then S_IDLE.
REQ-021 SHALL keep count and outstanding counters at width $clog2(FIFO_DEPTH)+1.

Reset
REQ-022 SHALL, with rst_ni low, immediately force state S_IDLE, all counters 0, FIFO empty, and req, valid_o and done_o at 0.
REQ-023 SHALL, on reset mid-transfer, discard all pending data; responses arriving after reset are ignored.

Configuration
REQ-024 SHALL, with IMN_STALL_CTR_EN defined, add output stall_cycles_o (32 bits, reset 0), incremented each cycle req && !gnt, saturating at 2^32-1, and cleared on start_i.
REQ-025 SHALL, without IMN_STALL_CTR_EN, have neither the port nor the counter logic.

Structure
REQ-026 SHALL place imn_fsm_t (S_IDLE, S_FETCH, S_DRAIN) and the IMN_FIFO_DEPTH default constant in cgra_pkg.
REQ-027 SHALL use obi_req_t and obi_resp_t from obi_pkg.
REQ-028 SHALL build the FIFO as sub-module imn_resp_fifo (push, pop, full, empty, count outputs).

Verification
REQ-029 SHALL test size 16, stride 4, base 0x1000, single-cycle gnt, rvalid on the next cycle, ready_i=1 -> addresses 0x1000/1004/1008/100C, 4 words in order, then done_o.
REQ-030 SHALL test size 8, stride 0xFFFC, base 0x0 -> addresses 0x0 then 0xFFFC, covering the stride applied to a 32-bit address.
REQ-031 SHALL test ready_i=0 for 20 cycles with size 32 and FIFO_DEPTH 4 -> at most 4 grants, req low thereafter, and data_o stable.
REQ-032 SHALL test size 3 -> done_o on the next cycle, with no req.
REQ-033 SHALL test rst_ni low after the 2nd grant with 1 response outstanding -> all outputs 0 at once; a later full transfer behaves as in REQ-029.
REQ-034 SHALL test, with IMN_STALL_CTR_EN defined, gnt held low 5 cycles on the first request -> stall_cycles_o = 5.
